// File: rtl/note_detector.sv
// Tone period detector: measures the rise-to-rise period of a square-wave input and
// classifies it against the C5..C6 note table with a stability-qualified valid flag.
module note_detector #(
  parameter int unsigned TOL     = 512,
  parameter int unsigned STABLE  = 2,
  parameter int unsigned TIMEOUT = 131071,
  parameter int unsigned CNT_W   = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic             period_strobe,
  output logic [3:0]       note_idx,
  output logic             note_valid
);

  localparam int unsigned NOTES = 13;
  localparam int unsigned RUN_W = 3;

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

  // Full-period reference for C5 (0) .. C6 (12)
  function automatic logic [CNT_W-1:0] ref_period(input int unsigned i);
    case (i)
      0:       ref_period = CNT_W'(95604);
      1:       ref_period = CNT_W'(90254);
      2:       ref_period = CNT_W'(85180);
      3:       ref_period = CNT_W'(80386);
      4:       ref_period = CNT_W'(75874);
      5:       ref_period = CNT_W'(71634);
      6:       ref_period = CNT_W'(67568);
      7:       ref_period = CNT_W'(63776);
      8:       ref_period = CNT_W'(60170);
      9:       ref_period = CNT_W'(56820);
      10:      ref_period = CNT_W'(53650);
      11:      ref_period = CNT_W'(50608);
      12:      ref_period = CNT_W'(47756);
      default: ref_period = '0;
    endcase
  endfunction

  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    logic [CNT_W:0] wa, wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    abs_diff = (wa >= wb) ? (wa - wb) : (wb - wa);
  endfunction

  logic             s1, s2, s3;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  state_t           state, state_d;
  logic [CNT_W-1:0] period_d;
  logic             strobe_d;
  logic [3:0]       cand, cand_d;
  logic [RUN_W-1:0] run, run_d;
  logic [3:0]       idx_d;
  logic             valid_d;
  logic             match;
  logic [3:0]       match_idx;

  assign rise = s2 & ~s3;

  // Synchronizer and saturating rise-to-rise counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s3  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= tone_in;
      s2 <= s1;
      s3 <= s2;
      if (rise)
        cnt <= '0;
      else if (cnt != CNT_W'(TIMEOUT))
        cnt <= cnt + CNT_W'(1);
    end
  end

  // Table lookup on the registered period; table spacing guarantees at most one hit
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = 0; i < int'(NOTES); i++) begin
      if (!match && abs_diff(period, ref_period(i)) <= (CNT_W+1)'(TOL)) begin
        match     = 1'b1;
        match_idx = 4'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      period        <= '0;
      period_strobe <= 1'b0;
      cand          <= '0;
      run           <= '0;
      note_idx      <= '0;
      note_valid    <= 1'b0;
    end else begin
      state         <= state_d;
      period        <= period_d;
      period_strobe <= strobe_d;
      cand          <= cand_d;
      run           <= run_d;
      note_idx      <= idx_d;
      note_valid    <= valid_d;
    end
  end

  always_comb begin
    state_d  = state;
    period_d = period;
    strobe_d = 1'b0;
    cand_d   = cand;
    run_d    = run;
    idx_d    = note_idx;
    valid_d  = note_valid;

    case (state)
      IDLE: begin
        if (rise)
          state_d = ARMED;
      end
      ARMED, LOCKED: begin
        if (rise) begin
          period_d = cnt + CNT_W'(1);
          strobe_d = 1'b1;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          valid_d = 1'b0;
          run_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Classification of the period captured on the previous cycle
    if (period_strobe) begin
      if (!match) begin
        run_d   = '0;
        valid_d = 1'b0;
        state_d = ARMED;
      end else begin
        if (match_idx == cand && run != '0) begin
          if (run < RUN_W'(STABLE))
            run_d = run + RUN_W'(1);
        end else begin
          cand_d = match_idx;
          run_d  = RUN_W'(1);
        end
        if (run_d >= RUN_W'(STABLE)) begin
          idx_d   = cand_d;
          valid_d = 1'b1;
          state_d = LOCKED;
        end else begin
          valid_d = 1'b0;
          state_d = ARMED;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_detector.sv
// Directed bench for note_detector: lock, tolerance edges, note change, silence, reset.
module tb_note_detector;

  logic        clk;
  logic        reset;
  logic        tone_in;
  logic [16:0] period;
  logic        period_strobe;
  logic [3:0]  note_idx;
  logic        note_valid;

  int tests;
  int fails;

  note_detector dut (
    .clk           (clk),
    .reset         (reset),
    .tone_in       (tone_in),
    .period        (period),
    .period_strobe (period_strobe),
    .note_idx      (note_idx),
    .note_valid    (note_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, 32'(period), 32'd0);
    check({tag, "_strobe"}, 32'(period_strobe), 32'd0);
    check({tag, "_idx"}, 32'(note_idx), 32'd0);
    check({tag, "_valid"}, 32'(note_valid), 32'd0);
  endtask

  // One tone period of p cycles starting with a rising edge at a negedge.
  // The strobe for this rise is visible 3 negedges later, classification one after.
  task automatic tone_period(input string tag, input int p,
                             input logic es, input int ep,
                             input logic ev, input int ei);
    tone_in = 1'b1;
    repeat (3) @(negedge clk);
    check({tag, "_strobe"}, 32'(period_strobe), 32'(es));
    check({tag, "_period"}, 32'(period), 32'(ep));
    @(negedge clk);
    check({tag, "_valid"}, 32'(note_valid), 32'(ev));
    check({tag, "_idx"}, 32'(note_idx), 32'(ei));
    check({tag, "_strobe_off"}, 32'(period_strobe), 32'd0);
    repeat (p / 2 - 4) @(negedge clk);
    tone_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    tone_in = 1'b0;

    // Reset held while the input toggles
    repeat (8) begin
      @(negedge clk);
      tone_in = ~tone_in;
    end
    check_all_zero("rst_hold");
    tone_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_all_zero("rst_rel");

    // G5 lock: first rise only arms
    tone_period("g5_arm", 63776, 1'b0, 0,     1'b0, 0);
    tone_period("g5_p1",  63776, 1'b1, 63776, 1'b0, 0);
    tone_period("g5_p2",  63776, 1'b1, 63776, 1'b1, 7);

    // Tolerance edges
    tone_period("tol_a",  64288, 1'b1, 63776, 1'b1, 7);
    tone_period("tol_p512", 64289, 1'b1, 64288, 1'b1, 7);
    tone_period("tol_p513", 63263, 1'b1, 64289, 1'b0, 7);
    tone_period("tol_m513", 63776, 1'b1, 63263, 1'b0, 7);

    // Relock G5, then switch to C6
    tone_period("chg_g1", 63776, 1'b1, 63776, 1'b0, 7);
    tone_period("chg_g2", 47756, 1'b1, 63776, 1'b1, 7);
    tone_period("chg_c1", 47756, 1'b1, 47756, 1'b0, 7);
    tone_period("chg_c2", 95604, 1'b1, 47756, 1'b1, 12);

    // C5 lock then silence
    tone_period("sil_c1", 95604, 1'b1, 95604, 1'b0, 12);
    tone_period("sil_c2", 95604, 1'b1, 95604, 1'b1, 0);
    repeat (131073 - 95604) @(negedge clk);
    check("sil_before", 32'(note_valid), 32'd1);
    @(negedge clk);
    check("sil_drop_valid", 32'(note_valid), 32'd0);
    check("sil_drop_idx", 32'(note_idx), 32'd0);
    check("sil_drop_period", 32'(period), 32'd95604);
    check("sil_drop_strobe", 32'(period_strobe), 32'd0);
    tone_period("sil_rearm", 1000,  1'b0, 95604, 1'b0, 0);
    tone_period("sil_next",  56820, 1'b1, 1000,  1'b0, 0);

    // A5 lock, then reset mid-lock
    tone_period("a5_p1", 56820, 1'b1, 56820, 1'b0, 0);
    tone_period("a5_p2", 56820, 1'b1, 56820, 1'b1, 9);
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    tone_period("a5_rearm", 56820, 1'b0, 0,     1'b0, 0);
    tone_period("a5_r1",    56820, 1'b1, 56820, 1'b0, 0);
    tone_period("a5_r2",    56820, 1'b1, 56820, 1'b1, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
